// File: rtl/txuart_pkg.sv
// txuart_pkg -- definitions shared by the UART transmitter and the future receiver.
//   * Bit positions of the fields in the 29-bit setup word.
//   * Encoding of the data-width field.
//   * The transmitter/receiver state encoding.
//   * Helper functions for the data mask and the index of the last data bit.
package txuart_pkg;

   localparam int SETUP_W     = 29;
   localparam int DIV_W       = 24;
   localparam int DBITS_HI    = 28;
   localparam int DBITS_LO    = 27;
   localparam int STOP2_BIT   = 26;
   localparam int PAR_EN_BIT  = 25;
   localparam int PAR_ODD_BIT = 24;

   // Data-width field: 00 selects 8 bits, and each step down removes one bit.
   typedef enum logic [1:0] {
      DBITS_8 = 2'b00,
      DBITS_7 = 2'b01,
      DBITS_6 = 2'b10,
      DBITS_5 = 2'b11
   } dbits_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } uart_state_e;

   // Keeps only the configured number of low data bits.
   function automatic logic [7:0] data_mask(input dbits_e dbits);
      return 8'hFF >> dbits;
   endfunction

   // Index of the last data bit: 7 for 8 bits, down to 4 for 5 bits.
   function automatic logic [2:0] last_bit_idx(input dbits_e dbits);
      return 3'd7 - {1'b0, dbits};
   endfunction

endpackage

// File: rtl/txuart_baudgen.sv
// txuart_baudgen -- baud divider for the UART transmitter.
// The divider loads D-1 (with D clamped to at least 2) and counts down to zero,
// so one bit period lasts exactly D clocks.
//   i_clk   : clock
//   i_reset : synchronous active-high reset (counter cleared to 0)
//   i_load  : reload the counter from i_div
//   i_div   : clocks per baud, D
//   o_zero  : baud strobe (the counter is at zero, i.e. the last clock of a bit)
//   o_one   : the counter is at one (the second-to-last clock of a bit)
module txuart_baudgen
   import txuart_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_load,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_zero,
   output logic             o_one
);

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_load) begin
         // D below 2 is treated as 2, so "one" always precedes "zero".
         cnt_d = (i_div < DIV_W'(2)) ? DIV_W'(1) : i_div - DIV_W'(1);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - DIV_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign o_zero = (cnt_q == '0);
   assign o_one  = (cnt_q == DIV_W'(1));

endmodule

// File: rtl/txuart_cfg.sv
// txuart_cfg -- configurable UART transmitter with break support.
// It sends 5 to 8 data bits, LSB first, with optional even or odd parity and
// one or two stop bits. The data and the frame setup are latched when a write
// is accepted.
//   i_clk     : clock (rising edge)
//   i_reset   : synchronous active-high reset
//   i_setup   : [28:27] data bits, [26] two stop bits, [25] parity enable,
//               [24] odd parity, [23:0] clocks per baud
//   i_wr      : write request, accepted only when idle and no break is requested
//   i_data    : byte to send
//   i_break   : hold the line low (break) while high
//   o_busy    : a frame or break is in progress
//   o_uart_tx : registered serial output, idle high
module txuart_cfg
   import txuart_pkg::*;
#(
   parameter logic [SETUP_W-1:0] INITIAL_SETUP = 29'h000008B
)(
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [SETUP_W-1:0] i_setup,
   input  logic               i_wr,
   input  logic [7:0]         i_data,
   input  logic               i_break,
   output logic               o_busy,
   output logic               o_uart_tx
);

   uart_state_e        state_q;
   logic [SETUP_W-1:0] setup_q;
   logic [7:0]         data_q;
   logic [2:0]         bit_cnt_q;
   logic               par_q;
   logic               stop2_q;
   logic               tx_q;
   logic               busy_q;

   logic               baud_zero;
   logic               baud_one;
   logic               accept;
   logic               baud_load;
   logic [DIV_W-1:0]   baud_div;

   // busy_q is already low on the last stop clock, so that clock also accepts
   // a back-to-back write.
   assign accept = i_wr && !busy_q && !i_break &&
                   ((state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_zero));

   // Reload on every bit boundary. In BREAK the counter is reloaded on every
   // clock, so the closing mark starts with a full period.
   assign baud_load = accept || (state_q == ST_BREAK) ||
                      ((state_q != ST_IDLE) && baud_zero);
   assign baud_div  = accept ? i_setup[DIV_W-1:0] : setup_q[DIV_W-1:0];

   txuart_baudgen u_baudgen (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_load  (baud_load),
      .i_div   (baud_div),
      .o_zero  (baud_zero),
      .o_one   (baud_one)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= ST_IDLE;
         setup_q   <= INITIAL_SETUP;
         data_q    <= '0;
         bit_cnt_q <= '0;
         par_q     <= 1'b0;
         stop2_q   <= 1'b0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else if (accept) begin
         state_q <= ST_START;
         setup_q <= i_setup;
         data_q  <= i_data & data_mask(dbits_e'(i_setup[DBITS_HI:DBITS_LO]));
         tx_q    <= 1'b0;
         busy_q  <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_break) begin
                  state_q <= ST_BREAK;
                  tx_q    <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            ST_START: begin
               if (baud_zero) begin
                  state_q   <= ST_DATA;
                  tx_q      <= data_q[0];
                  data_q    <= data_q >> 1;
                  bit_cnt_q <= last_bit_idx(dbits_e'(setup_q[DBITS_HI:DBITS_LO]));
                  // data_q is already masked, so the XOR covers only the sent bits.
                  par_q     <= (^data_q) ^ setup_q[PAR_ODD_BIT];
               end
            end
            ST_DATA: begin
               if (baud_zero) begin
                  if (bit_cnt_q != 3'd0) begin
                     tx_q      <= data_q[0];
                     data_q    <= data_q >> 1;
                     bit_cnt_q <= bit_cnt_q - 3'd1;
                  end else if (setup_q[PAR_EN_BIT]) begin
                     state_q <= ST_PARITY;
                     tx_q    <= par_q;
                  end else begin
                     state_q <= ST_STOP;
                     tx_q    <= 1'b1;
                     stop2_q <= setup_q[STOP2_BIT];
                  end
               end
            end
            ST_PARITY: begin
               if (baud_zero) begin
                  state_q <= ST_STOP;
                  tx_q    <= 1'b1;
                  stop2_q <= setup_q[STOP2_BIT];
               end
            end
            ST_STOP: begin
               if (baud_zero) begin
                  if (stop2_q) begin
                     stop2_q <= 1'b0;
                  end else if (i_break) begin
                     state_q <= ST_BREAK;
                     tx_q    <= 1'b0;
                     busy_q  <= 1'b1;
                  end else begin
                     state_q <= ST_IDLE;
                     tx_q    <= 1'b1;
                     busy_q  <= 1'b0;
                  end
               end else if (baud_one && !stop2_q) begin
                  // busy_q falls one clock early so it is low on the last stop clock.
                  busy_q <= 1'b0;
               end
            end
            ST_BREAK: begin
               // The mark after a break reuses STOP as a single stop bit.
               if (!i_break) begin
                  state_q <= ST_STOP;
                  tx_q    <= 1'b1;
                  stop2_q <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy    = busy_q;
   assign o_uart_tx = tx_q;

endmodule

// File: tb/tb_txuart_cfg.sv
// tb_txuart_cfg -- directed bench for txuart_cfg.
// Each vector uses hand-written serial bit strings. In these strings the
// rightmost bit is sent first.
module tb_txuart_cfg;

   logic        i_clk;
   logic        i_reset;
   logic [28:0] i_setup;
   logic        i_wr;
   logic [7:0]  i_data;
   logic        i_break;
   logic        o_busy;
   logic        o_uart_tx;

   int n_checks;
   int n_errors;

   txuart_cfg dut (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_setup   (i_setup),
      .i_wr      (i_wr),
      .i_data    (i_data),
      .i_break   (i_break),
      .o_busy    (o_busy),
      .o_uart_tx (o_uart_tx)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // This task is entered just after a negedge. It issues a write that is
   // accepted on the next posedge, and then checks every cycle of nfr frames.
   // Each frame has nbit bits of d clocks. o_busy is expected low only on the
   // last clock of each frame. At frame clock wr_at a second write (d2, s2) is
   // raised for one cycle.
   task automatic run_frame(input string tag, input logic [28:0] setup, input logic [7:0] data,
                            input logic [31:0] bits, input int nbit, input int nfr, input int d,
                            input int wr_at, input logic [7:0] d2, input logic [28:0] s2);
      int flen;
      int total;
      logic exp_tx;
      logic exp_busy;
      flen  = nbit * d;
      total = flen * nfr;
      i_setup = setup;
      i_data  = data;
      i_wr    = 1'b1;
      @(negedge i_clk);
      for (int k = 0; k <= total; k++) begin
         if (k != 0) @(negedge i_clk);
         exp_tx   = (k < total) ? bits[k / d] : 1'b1;
         exp_busy = (k < total) && ((k % flen) != flen - 1);
         check($sformatf("%s_tx_k%0d", tag, k), 32'(o_uart_tx), 32'(exp_tx));
         check($sformatf("%s_busy_k%0d", tag, k), 32'(o_busy), 32'(exp_busy));
         i_wr = (k == wr_at);
         if (k == wr_at) begin
            i_data  = d2;
            i_setup = s2;
         end
      end
      i_wr = 1'b0;
      $display("frame %s: %0d cycles checked, errors so far %0d", tag, total + 1, n_errors);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      i_reset  = 1'b1;
      i_setup  = 29'h0000004;
      i_wr     = 1'b0;
      i_data   = 8'h00;
      i_break  = 1'b0;
      repeat (3) @(negedge i_clk);
      check("reset_tx", 32'(o_uart_tx), 32'd1);
      check("reset_busy", 32'(o_busy), 32'd0);
      i_reset = 1'b0;
      @(negedge i_clk);
      check("idle_tx", 32'(o_uart_tx), 32'd1);
      check("idle_busy", 32'(o_busy), 32'd0);
      $display("reset: done");

      // 8N1, D=4, data 0x55. A write of 0x00 with setup D=2 at frame clock 10
      // must have no effect: the write is not accepted and the setup is not latched.
      run_frame("8n1_55", 29'h0000004, 8'h55, 32'(10'b1_01010101_0), 10, 1, 4,
                10, 8'h00, 29'h0000002);
      // 7E2, D=4, data 0x41: data bits 1000001, parity 0, two stop bits.
      run_frame("7e2_41", 29'h0E000004, 8'h41, 32'(11'b11_0_1000001_0), 11, 1, 4,
                -1, 8'h00, 29'h0E000004);
      // 5O1, D=4, data 0xFF: five ones, odd parity 0, one stop bit.
      run_frame("5o1_ff", 29'h1B000004, 8'hFF, 32'(8'b1_0_11111_0), 8, 1, 4,
                -1, 8'h00, 29'h1B000004);
      // Back-to-back 8N1 writes: 0xA5, then 0x3C issued on the clock where o_busy is low.
      run_frame("b2b", 29'h0000004, 8'hA5, 32'({10'b1_00111100_0, 10'b1_10100101_0}), 10, 2, 4,
                39, 8'h3C, 29'h0000004);

      // Reset during data bit 3 of 0xF0 (that bit is 0, so the line is low).
      i_setup = 29'h0000004;
      i_data  = 8'hF0;
      i_wr    = 1'b1;
      @(negedge i_clk);
      i_wr = 1'b0;
      for (int k = 1; k <= 17; k++) @(negedge i_clk);
      check("rst_mid_tx_before", 32'(o_uart_tx), 32'd0);
      check("rst_mid_busy_before", 32'(o_busy), 32'd1);
      i_reset = 1'b1;
      @(negedge i_clk);
      i_reset = 1'b0;
      check("rst_mid_tx_after", 32'(o_uart_tx), 32'd1);
      check("rst_mid_busy_after", 32'(o_busy), 32'd0);
      $display("reset mid-frame: done");
      run_frame("after_rst_00", 29'h0000004, 8'h00, 32'(10'b1_00000000_0), 10, 1, 4,
                -1, 8'h00, 29'h0000004);

      // Break from IDLE: i_break is high for 20 clocks with D=4.
      for (int k = 0; k <= 26; k++) begin
         if (k != 0) @(negedge i_clk);
         check($sformatf("brk_tx_k%0d", k), 32'(o_uart_tx), 32'(!(k >= 1 && k <= 20)));
         check($sformatf("brk_busy_k%0d", k), 32'(o_busy), 32'(k >= 1 && k <= 23));
         i_break = (k < 20);
      end
      i_break = 1'b0;
      $display("break: done, errors so far %0d", n_errors);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
